// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding (matches the transmitter), frame sizes, vote helper.
package uart_pkg;
    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'b00;
    localparam uart_state_t START = 2'b01;
    localparam uart_state_t DATA  = 2'b10;
    localparam uart_state_t STOP  = 2'b11;

    localparam int UART_FRAME_BITS = 8;  // parity + data
    localparam int UART_DATA_BITS  = 7;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous RX pin; both flops reset to RST_VAL.
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetN,
    input  logic d_i,
    output logic q_o
);
    logic meta_q, sync_q;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;
endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: start, odd parity, 7 data bits MSB first, stop.
// Define UART_RX_MAJORITY_EN for 2-of-3 voting around each sample point.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      rx,
    input  logic                      rx_en,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      valid,
    output logic                      parity_err,
    output logic                      frame_err,
    output logic                      busy
);
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(UART_FRAME_BITS);
    localparam logic [CW-1:0] HALF_P = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_P = CW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] LAST_BIT = NW'(UART_FRAME_BITS - 1);

    logic rx_s, bit_s;

    uart_rx_sync #(.RST_VAL(1'b1)) u_sync (
        .clk    (clk),
        .resetN (resetN),
        .d_i    (rx),
        .q_o    (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    // Two previous ticks' samples; at the decision tick these are P-2 and P-1.
    logic [1:0] hist_q;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)    hist_q <= 2'b11;
        else if (rx_en) hist_q <= {hist_q[0], rx_s};
    end
    assign bit_s = maj3(hist_q[1], hist_q[0], rx_s);
`else
    assign bit_s = rx_s;
`endif

    uart_state_t                state_q, state_d;
    logic [CW-1:0]              cnt_q, cnt_d;
    logic [NW-1:0]              nbit_q, nbit_d;
    logic [UART_FRAME_BITS-1:0] shreg_q, shreg_d;
    logic                       armed_q, armed_d;
    logic [UART_DATA_BITS-1:0]  data_q, data_d;
    logic                       perr_q, perr_d, ferr_q, ferr_d, valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nbit_d  = nbit_q;
        shreg_d = shreg_q;
        armed_d = armed_q;
        data_d  = data_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        valid_d = 1'b0;
        if (rx_en) begin
            case (state_q)
                IDLE: begin
                    if (rx_s) begin
                        armed_d = 1'b1;
                    end else if (armed_q) begin
                        cnt_d   = '0;
                        state_d = START;
                    end
                end
                START: begin
                    if (cnt_q == HALF_P) begin
                        if (bit_s) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d   = '0;
                            nbit_d  = '0;
                            state_d = DATA;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == FULL_P) begin
                        cnt_d   = '0;
                        shreg_d = {shreg_q[UART_FRAME_BITS-2:0], bit_s};
                        nbit_d  = nbit_q + 1'b1;
                        if (nbit_q == LAST_BIT) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == FULL_P) begin
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        data_d  = shreg_q[UART_DATA_BITS-1:0];
                        perr_d  = ~(^shreg_q);
                        ferr_d  = ~bit_s;
                        // A low stop bit may be a break: wait for the line to go high again.
                        if (!bit_s) armed_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nbit_q  <= '0;
            shreg_q <= '0;
            armed_q <= 1'b1;
            data_q  <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nbit_q  <= nbit_d;
            shreg_q <= shreg_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frame-level expectation queue plus literal spot checks.
module tb_uart_receiver;
    logic       clk, resetN, rx, rx_en;
    logic [6:0] data_out;
    logic       valid, parity_err, frame_err, busy;

    int errors = 0;
    int checks = 0;
    int nvalid = 0;

    typedef struct packed {
        logic [6:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t expq[$];
    exp_t last = '0;
    exp_t cur;

    uart_receiver #(.OVERSAMPLE(16)) dut (
        .clk        (clk),
        .resetN     (resetN),
        .rx         (rx),
        .rx_en      (rx_en),
        .data_out   (data_out),
        .valid      (valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One oversample period: line value held for 4 clk, rx_en pulse on the last one.
    task automatic one_tick(input logic v);
        rx = v;
        repeat (3) @(negedge clk);
        rx_en = 1'b1;
        @(negedge clk);
        rx_en = 1'b0;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) one_tick(1'b1);
    endtask

    // Sends a full frame; gpos selects a frame bit whose centre tick is inverted (-1: none).
    task automatic send_frame(input logic [6:0] ch, input bit pflip, input logic stop, input int gpos);
        logic [9:0] fr;
        logic       par;
        logic [6:0] rcv;
        exp_t       e;
        par = ~(^ch);
        if (pflip) par = ~par;
        fr[0] = 1'b0;
        fr[1] = par;
        for (int k = 0; k < 7; k++) fr[2 + k] = ch[6 - k];
        fr[9] = stop;
        rcv = ch;
`ifndef UART_RX_MAJORITY_EN
        if (gpos >= 2 && gpos <= 8) rcv[8 - gpos] = ~rcv[8 - gpos];
`endif
        e.d  = rcv;
        e.pe = ($countones({par, rcv}) % 2) == 0;
        e.fe = ~stop;
        expq.push_back(e);
        for (int b = 0; b < 10; b++)
            for (int t = 0; t < 16; t++)
                one_tick((b == gpos && t == 8) ? ~fr[b] : fr[b]);
    endtask

    // Checker: reset values, one expected frame per valid pulse, outputs held between pulses.
    always begin
        @(posedge clk);
        #1;
        if (!resetN) begin
            expq.delete();
            last = '0;
            chk("rst_data", data_out, 0);
            chk("rst_valid", valid, 0);
            chk("rst_perr", parity_err, 0);
            chk("rst_ferr", frame_err, 0);
            chk("rst_busy", busy, 0);
        end else if (valid) begin
            nvalid++;
            chk("busy_at_valid", busy, 0);
            if (expq.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                cur = expq.pop_front();
                chk("frame_data", data_out, cur.d);
                chk("frame_perr", parity_err, cur.pe);
                chk("frame_ferr", frame_err, cur.fe);
                last = cur;
            end
        end else begin
            chk("held_data", data_out, last.d);
            chk("held_perr", parity_err, last.pe);
            chk("held_ferr", frame_err, last.fe);
        end
    end

    int nv0;

    initial begin
        resetN = 1'b0;
        rx     = 1'b1;
        rx_en  = 1'b0;
        repeat (5) @(negedge clk);
        resetN = 1'b1;
        idle_ticks(20);

        // Clean frame
        nv0 = nvalid;
        send_frame(7'h41, 0, 1'b1, -1);
        idle_ticks(4);
        chk("clean_data", data_out, 7'h41);
        chk("clean_perr", parity_err, 0);
        chk("clean_ferr", frame_err, 0);
        chk("clean_nvalid", nvalid - nv0, 1);

        // Parity error
        send_frame(7'h41, 1, 1'b1, -1);
        idle_ticks(4);
        chk("par_data", data_out, 7'h41);
        chk("par_perr", parity_err, 1);

        // Frame error followed by a break
        nv0 = nvalid;
        send_frame(7'h7F, 0, 1'b0, -1);
        for (int i = 0; i < 48; i++) one_tick(1'b0);
        chk("brk_data", data_out, 7'h7F);
        chk("brk_ferr", frame_err, 1);
        chk("brk_perr", parity_err, 0);
        chk("brk_busy", busy, 0);
        chk("brk_nvalid", nvalid - nv0, 1);
        idle_ticks(4);
        send_frame(7'h2A, 0, 1'b1, -1);
        idle_ticks(4);
        chk("after_brk_data", data_out, 7'h2A);
        chk("after_brk_ferr", frame_err, 0);

        // False start
        nv0 = nvalid;
        for (int i = 0; i < 4; i++) one_tick(1'b0);
        chk("fs_busy_hi", busy, 1);
        idle_ticks(12);
        chk("fs_busy_lo", busy, 0);
        chk("fs_nvalid", nvalid - nv0, 0);

        // Back-to-back frames
        nv0 = nvalid;
        send_frame(7'h00, 0, 1'b1, -1);
        send_frame(7'h55, 0, 1'b1, -1);
        chk("b2b_nvalid", nvalid - nv0, 2);
        chk("b2b_data", data_out, 7'h55);

        // Reset in the middle of a third frame's data bits
        one_tick(1'b0);
        for (int i = 0; i < 16; i++) one_tick(1'b0);
        for (int i = 0; i < 48; i++) one_tick(i < 32 ? 1'b1 : 1'b0);
        chk("pre_rst_busy", busy, 1);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        resetN = 1'b1;
        idle_ticks(20);
        send_frame(7'h2A, 0, 1'b1, -1);
        idle_ticks(4);
        chk("post_rst_data", data_out, 7'h2A);
        chk("post_rst_perr", parity_err, 0);

        // Glitch on the centre tick of data bit 3
        send_frame(7'h41, 0, 1'b1, 5);
        idle_ticks(4);
`ifdef UART_RX_MAJORITY_EN
        chk("glitch_data", data_out, 7'h41);
        chk("glitch_perr", parity_err, 0);
`else
        chk("glitch_data", data_out, 7'h49);
        chk("glitch_perr", parity_err, 1);
`endif

        idle_ticks(4);
        chk("all_frames_seen", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receiver: the receive end of the team's UART link, paired with the existing transmitter. It accepts frames of one start bit (0), one odd-parity bit, seven data bits MSB first and one stop bit (1). The receiver oversamples `rx` on an external tick, locates the centre of each bit, checks parity and stop bit, and presents the 7-bit character with a one-cycle `valid` strobe. It sits between the board RX pin and the character consumer.

## Interface
- `OVERSAMPLE`, default 16: `rx_en` ticks per bit period; even and at least 8.
- `clk`  in  1  system clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; asynchronous to `clk`; idles high.
- `rx_en`  in  1  oversample tick, one `clk` wide, at OVERSAMPLE × baud.
- `data_out`  out  7  last received character; reset 0; held until the next `valid`.
- `valid`  out  1  one-`clk` pulse when a frame completes; reset 0.
- `parity_err`  out  1  parity status of the last frame; reset 0; updated with `valid`.
- `frame_err`  out  1  stop-bit status of the last frame; reset 0; updated with `valid`.
- `busy`  out  1  high whenever the state is not IDLE; reset 0.

## Operation
- `rx` passes through a 2-flop synchronizer with a reset value of 1. All decisions use the synchronized `rx_s`.
- The state machine has four states. Its tick counter `cnt` and bit counter `nbit` advance only on `rx_en`.
- **IDLE (00)**
  - On a tick with `rx_s`=0 and `armed`=1: clear `cnt`, go to START.
  - `armed` sets on any tick with `rx_s`=1.
- **START (01)**
  - `cnt` increments each tick. The sample is taken at `cnt`==OVERSAMPLE/2−1, which is 8 ticks after detection.
  - Sample 1 (false start): return to IDLE with no `valid`.
  - Sample 0: clear `cnt` and `nbit`, go to DATA.
- **DATA (10)**
  - A sample is taken at each `cnt`==OVERSAMPLE−1, one bit period apart. At that tick `cnt` wraps to 0.
  - Each sample shifts into `shreg[7:0]` from the LSB side. The first bit received (parity) ends up in `shreg[7]`.
  - After the 8th sample, go to STOP.
- **STOP (11)**
  - Sample at `cnt`==OVERSAMPLE−1.
  - On the next `clk`, the outputs update: `data_out`←`shreg[6:0]`, `parity_err`←~(^`shreg`) (odd total parity required), `frame_err`←~sample, and `valid`=1 for that cycle. Go to IDLE.
  - If `frame_err`=1, clear `armed`. A held-low line (break) then cannot retrigger until `rx_s` returns high.
- `valid` pulses even when an error flag is set. `data_out` is always loaded.
- If `rx_en` is high with no sample point due, only `cnt` advances.
- When `resetN` is asserted mid-frame, every state, counter and output returns to its reset value at once, and `armed` is set to 1.

## Timing
- Synchronizer latency is 2 `clk`. Start detection happens on the first `rx_en` after `rx_s` falls.
- Sample points are bit start + OVERSAMPLE/2 ticks, to within ±1 tick of detection jitter.
- Valid latency is 1 `clk` after the stop-bit sample tick.
- The earliest next start detection is the first tick after `valid` on which `rx_s`=0, so back-to-back frames with a one-bit stop are supported.
- `busy` rises 1 `clk` after the detection tick. It falls in the same cycle as `valid`, or 1 `clk` after a false-start sample.

## Configuration
- The macro `UART_RX_MAJORITY_EN` selects the sampling method.
- Defined:
  - Every bit decision is the 2-of-3 majority of samples at `cnt` = P−2, P−1 and P, decided at P.
  - P is the nominal sample point: OVERSAMPLE/2−1 in START and OVERSAMPLE−1 in DATA and STOP.
  - A single-tick glitch is rejected.
- Undefined: a single sample is taken at P, and a glitch on that tick is accepted.

## Structure
- Package `uart_pkg`:
  - state typedef: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11, matching the transmitter encoding.
  - `UART_FRAME_BITS`=8 (parity + data).
  - `UART_DATA_BITS`=7.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with a parameterised reset value of 1.

## Test plan
- **Clean frame.**
  - Stimulus: send 7'h41 at OVERSAMPLE=16. Line sequence is 0, 1,1,0,0,0,0,0,1, 1 (start, parity=1, data MSB first, stop).
  - Required: `data_out`=7'h41, `valid` for exactly one `clk`, `parity_err`=0, `frame_err`=0.
- **Parity error.**
  - Stimulus: the same frame with the parity bit set to 0.
  - Required: `valid`=1, `data_out`=7'h41, `parity_err`=1.
- **Frame error and break.**
  - Stimulus: send 7'h7F with the stop bit 0, then hold `rx` low for 3 bit times.
  - Required: `frame_err`=1 and a single `valid`. No further `valid` until `rx` goes high and a new frame is sent.
- **False start.**
  - Stimulus: drive `rx` low for 4 ticks, then high.
  - Required: no `valid`, and `busy` drops after the START sample.
- **Back-to-back frames and reset.**
  - Stimulus: send 7'h00 then 7'h55 with no idle gap. Then assert `resetN` mid-way through the DATA bits of a third frame.
  - Required: two valid characters with correct flags. All outputs return to 0 on reset, and the next clean frame is received correctly.
- **Glitch (UART_RX_MAJORITY_EN defined).**
  - Stimulus: a one-tick inverted glitch at the sample point of data bit 3.
  - Required: the correct character with no errors. With the macro undefined, the corrupted bit is visible and `parity_err`=1.
